// File: rtl/flow_fifo_pkg.sv
// Shared width helpers for the flow_fifo elastic buffer.
package flow_fifo_pkg;

    function automatic int ptr_width(input int num);
        return (num > 1) ? $clog2(num) : 1;
    endfunction

    function automatic int cnt_width(input int num);
        return $clog2(num + 1);
    endfunction

endpackage

// File: rtl/flow_fifo_mem.sv
// Storage array for flow_fifo: one write port, one asynchronous read port, no reset.
module flow_fifo_mem
    import flow_fifo_pkg::*;
#(
    parameter int NUM   = 8,
    parameter int WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [ptr_width(NUM)-1:0]   wr_addr,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic [ptr_width(NUM)-1:0]   rd_addr,
    output logic [WIDTH-1:0]            rd_data
);

    logic [WIDTH-1:0] mem [NUM];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/flow_fifo.sv
// Ready/valid FIFO with registered head stage, occupancy count and almost flags.
// Define FLOW_FIFO_BYPASS_EN for a zero-latency path while the FIFO is empty.
module flow_fifo
    import flow_fifo_pkg::*;
#(
    parameter int NUM       = 8,
    parameter int WIDTH     = 32,
    parameter int AF_MARGIN = 1,
    parameter int AE_MARGIN = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        IN_flush,
    input  logic [WIDTH-1:0]            IN_data,
    input  logic                        IN_valid,
    output logic                        IN_ready,
    output logic [WIDTH-1:0]            OUT_data,
    output logic                        OUT_valid,
    input  logic                        OUT_ready,
    output logic [cnt_width(NUM)-1:0]   OUT_count,
    output logic                        OUT_almostFull,
    output logic                        OUT_almostEmpty
);

    localparam int PW = ptr_width(NUM);
    localparam int CW = cnt_width(NUM);
    localparam logic [PW-1:0] PTR_LAST = PW'(NUM - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(NUM);
    localparam logic [CW-1:0] CNT_AF   = CW'(NUM - AF_MARGIN);
    localparam logic [CW-1:0] CNT_AE   = CW'(AE_MARGIN);

    logic [PW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] out_data_reg, out_data_next;
    logic             out_valid_reg, out_valid_next;
    logic             in_ready_reg, in_ready_next;
    logic             af_reg, af_next;
    logic             ae_reg, ae_next;

    logic             push, pop, mem_empty, load_out, mem_we;
    logic             byp_active, bypass_take;
    logic [WIDTH-1:0] rd_data;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

`ifdef FLOW_FIFO_BYPASS_EN
    assign byp_active = (count_reg == '0) && IN_valid;
`else
    assign byp_active = 1'b0;
`endif

    assign bypass_take = byp_active && OUT_ready;
    assign OUT_valid   = out_valid_reg || byp_active;
    assign OUT_data    = byp_active ? IN_data : out_data_reg;

    always_comb begin
        push           = IN_valid && in_ready_reg;
        pop            = OUT_valid && OUT_ready;
        // Memory holds everything except the entry sitting in the head register.
        mem_empty      = (count_reg == CW'(out_valid_reg));
        load_out       = !out_valid_reg || pop;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        mem_we         = 1'b0;

        if (IN_flush) begin
            wr_ptr_next    = '0;
            rd_ptr_next    = '0;
            count_next     = '0;
            out_valid_next = 1'b0;
        end else begin
            if (load_out) begin
                if (!mem_empty) begin
                    out_data_next  = rd_data;
                    out_valid_next = 1'b1;
                    rd_ptr_next    = ptr_inc(rd_ptr_reg);
                end else if (push && !bypass_take) begin
                    out_data_next  = IN_data;
                    out_valid_next = 1'b1;
                end else begin
                    out_valid_next = 1'b0;
                end
            end
            mem_we = rst && push && !bypass_take && !(load_out && mem_empty);
            if (mem_we) begin
                wr_ptr_next = ptr_inc(wr_ptr_reg);
            end
            if (push && !pop) begin
                count_next = count_reg + 1'b1;
            end else if (pop && !push) begin
                count_next = count_reg - 1'b1;
            end
        end

        in_ready_next = (count_next != CNT_FULL);
        af_next       = (count_next >= CNT_AF);
        ae_next       = (count_next <= CNT_AE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            af_reg        <= 1'b0;
            ae_reg        <= 1'b1;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            in_ready_reg  <= in_ready_next;
            af_reg        <= af_next;
            ae_reg        <= ae_next;
        end
    end

    flow_fifo_mem #(
        .NUM   (NUM),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .wr_addr (wr_ptr_reg),
        .wr_data (IN_data),
        .rd_addr (rd_ptr_reg),
        .rd_data (rd_data)
    );

    assign IN_ready        = in_ready_reg;
    assign OUT_count       = count_reg;
    assign OUT_almostFull  = af_reg;
    assign OUT_almostEmpty = ae_reg;

endmodule

// File: tb/tb_flow_fifo.sv
// Scoreboard bench for flow_fifo (NUM=5, WIDTH=8): queue-based occupancy model plus data monitor.
module tb_flow_fifo;

    localparam int NUM = 5;
    localparam int AFM = 1;
    localparam int AEM = 1;
`ifdef FLOW_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       IN_flush = 1'b0;
    logic [7:0] IN_data = 8'h00;
    logic       IN_valid = 1'b0;
    logic       IN_ready;
    logic [7:0] OUT_data;
    logic       OUT_valid;
    logic       OUT_ready = 1'b0;
    logic [2:0] OUT_count;
    logic       OUT_almostFull;
    logic       OUT_almostEmpty;

    int total = 0;
    int bad = 0;
    int mcount = 0;
    bit was_reset = 1'b0;
    logic [7:0] exp_q[$];

    flow_fifo #(.NUM(NUM), .WIDTH(8), .AF_MARGIN(AFM), .AE_MARGIN(AEM)) dut (
        .clk             (clk),
        .rst             (rst),
        .IN_flush        (IN_flush),
        .IN_data         (IN_data),
        .IN_valid        (IN_valid),
        .IN_ready        (IN_ready),
        .OUT_data        (OUT_data),
        .OUT_valid       (OUT_valid),
        .OUT_ready       (OUT_ready),
        .OUT_count       (OUT_count),
        .OUT_almostFull  (OUT_almostFull),
        .OUT_almostEmpty (OUT_almostEmpty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // One clock: drive inputs after the edge, then check/update the model mid-cycle.
    task automatic step(input logic v, input logic [7:0] d, input logic ordy,
                        input logic fl, input logic rn);
        bit acc, tk, mv;
        @(posedge clk);
        #1;
        IN_valid  = v;
        IN_data   = d;
        OUT_ready = ordy;
        IN_flush  = fl;
        rst       = rn;
        @(negedge clk);
        if (was_reset) chk("reset_out_data", int'(OUT_data), 0);
        if (!rst) begin
            mcount = 0;
            exp_q.delete();
        end else begin
            mv = (mcount != 0) || (BYP && IN_valid);
            chk("count",        int'(OUT_count),       mcount);
            chk("in_ready",     int'(IN_ready),        int'(mcount != NUM));
            chk("out_valid",    int'(OUT_valid),       int'(mv));
            chk("almost_full",  int'(OUT_almostFull),  int'(mcount >= NUM - AFM));
            chk("almost_empty", int'(OUT_almostEmpty), int'(mcount <= AEM));
            if (IN_flush) begin
                mcount = 0;
                exp_q.delete();
            end else begin
                acc = IN_valid && (mcount != NUM);
                tk  = mv && OUT_ready;
                if (acc) exp_q.push_back(IN_data);
                mcount = mcount + int'(acc) - int'(tk);
            end
        end
        was_reset = !rst;
    endtask

    task automatic drain();
        repeat (NUM + 2) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    endtask

    // Monitor: compares the presented head against the scoreboard, pops on handshake.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst && !IN_flush && OUT_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_out: got %02h required nothing", OUT_data);
                end else begin
                    if (OUT_data !== exp_q[0]) begin
                        bad++;
                        $display("FAIL out_data: got %02h required %02h", OUT_data, exp_q[0]);
                    end
                    if (OUT_ready) begin
                        $display("pop data=%02h left=%0d", exp_q[0], exp_q.size() - 1);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Fill then drain
        for (int i = 0; i < NUM; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        drain();

        // Sustained streaming across pointer wrap
        for (int i = 0; i < 50; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
        drain();

        // Full with simultaneous pop and offered push
        for (int i = 0; i < NUM; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1);
        drain();

        // Flush with push and pop in the same cycle
        for (int i = 0; i < 3; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b1, 1'b1, 1'b1);
        drain();

        // Reset mid-stream together with flush
        for (int i = 0; i < 4; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        drain();

        // Empty-FIFO push with and without a ready consumer
        step(1'b1, 8'h77, 1'b1, 1'b0, 1'b1);
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drain();

        // Randomized traffic with varying producer/consumer pressure
        for (int i = 0; i < 400; i++) begin
            int phase;
            phase = i / 100;
            step(($urandom_range(0, 3) < 3 - (phase % 2)) ? 1'b1 : 1'b0,
                 8'($urandom),
                 ($urandom_range(0, 3) < 1 + (phase % 3)) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1);
        end
        drain();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flow_fifo.md
Name: flow_fifo

Overview:
- Synchronous, parametrised FIFO. Successor to the single-clock pointer FIFO.
- Adds a full ready/valid handshake on both sides and arbitrary (non-power-of-2) depth.
- Adds an occupancy count, almost-full/almost-empty flags and a synchronous flush.
- Used as the general elastic buffer between pipeline stages and as a decoupling queue in front of slow consumers.

Parameters:
- NUM, 8, capacity in entries; any value >= 2, power of 2 not required.
- WIDTH, 32, data width in bits; >= 1.
- AF_MARGIN, 1, OUT_almostFull asserts when count >= NUM-AF_MARGIN; range 0..NUM-1.
- AE_MARGIN, 1, OUT_almostEmpty asserts when count <= AE_MARGIN; range 0..NUM-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- IN_flush  in  1  synchronous flush; drops all contents.
- IN_data  in  WIDTH  write data.
- IN_valid  in  1  producer offers IN_data.
- IN_ready  out  1  FIFO can accept this cycle.
- OUT_data  out  WIDTH  head entry.
- OUT_valid  out  1  OUT_data holds a valid head.
- OUT_ready  in  1  consumer takes head this cycle.
- OUT_count  out  $clog2(NUM+1)  entries held, 0..NUM.
- OUT_almostFull  out  1  see AF_MARGIN.
- OUT_almostEmpty  out  1  see AE_MARGIN.

Behaviour:
- Reset (rst==0 at a rising edge):
  - wrPtr, rdPtr and count go to 0.
  - OUT_valid=0, OUT_data=0, IN_ready=1, OUT_almostFull=0, OUT_almostEmpty=1.
  - Memory contents are not reset.
  - Reset overrides flush, push and pop in the same cycle. Reset mid-stream discards everything.
- Handshake: push = IN_valid && IN_ready; pop = OUT_valid && OUT_ready.
  - IN_valid may be asserted while IN_ready=0; nothing is taken.
  - IN_ready does not depend combinationally on OUT_ready (no pass-through when full).
- Storage:
  - NUM-entry memory plus a registered output stage. The output register is counted in count; total capacity is exactly NUM.
- Latency:
  - An item pushed in cycle c into an empty FIFO shows OUT_valid=1 and its data in cycle c+1. The output register loads straight from IN_data.
  - When the output register is valid and pop occurs, the next entry, from memory or from a same-cycle push if memory is empty, is in OUT_data in the following cycle. There are no bubbles under sustained push and pop.
- Ordering: strict FIFO order; no data is lost or duplicated.
- Count update: push&&!pop adds 1; pop&&!push subtracts 1; otherwise unchanged.
- Registered flags:
  - IN_ready = (count != NUM).
  - OUT_almostFull = (count >= NUM-AF_MARGIN).
  - OUT_almostEmpty = (count <= AE_MARGIN).
  - All three are computed from next-state count so that they are valid in the same cycle as OUT_count.
- Pointers: wrap from NUM-1 to 0 by explicit compare, not by natural overflow. Width is $clog2(NUM).
- Boundaries:
  - Full: IN_ready=0; pop frees a slot, and IN_ready=1 in the next cycle.
  - Empty: OUT_valid=0; OUT_data holds its last value.
  - Full plus pop plus IN_valid: the push is not accepted that cycle.
  - Empty plus push: only the push happens (pop is impossible).
- Flush (IN_flush==1, rst==1):
  - Next cycle count=0, pointers 0, OUT_valid=0, IN_ready=1.
  - A push or pop in the flush cycle is ignored. The producer treats its IN_valid item as not accepted.
  - OUT_data is unchanged.

Optional Feature:
- Macro: FLOW_FIFO_BYPASS_EN.
- Defined:
  - When count==0, OUT_valid=IN_valid and OUT_data=IN_data combinationally, giving zero latency.
  - If OUT_ready is also high in that cycle, the item is consumed, not stored, and count stays 0.
  - IN_ready is unaffected.
- Undefined: no combinational IN-to-OUT path; minimum latency is 1 cycle as above.

Decomposition:
- Package flow_fifo_pkg holds:
  - Function ptr_width(num), returning max(1, $clog2(num)).
  - Function cnt_width(num), returning $clog2(num+1).
- Sub-module flow_fifo_mem: simple dual-port RAM with one write port and one asynchronous read port; parameters NUM and WIDTH; no reset. This keeps the RAM inferable separately.
- Control, count, flags and the output register stay in flow_fifo.

Test Plan:
All scenarios use NUM=5, WIDTH=8, AF_MARGIN=1, AE_MARGIN=1, bypass undefined unless stated.
1. Fill/drain: push 0x10..0x14 with OUT_ready=0.
   - Expected: count 1..5; IN_ready=0 after the 5th push; OUT_almostFull=1 at count 4.
   - Then OUT_ready=1: outputs 0x10..0x14 in order, one per cycle; count reaches 0; OUT_almostEmpty=1 at count<=1.
2. Streaming: IN_valid=1 and OUT_ready=1 continuously with an incrementing pattern.
   - Expected: after 1 cycle of latency, throughput is 1 item/cycle with no gaps; count stays 1.
   - Run 50 items to exercise pointer wrap at non-power-of-2 NUM.
3. Full with simultaneous pop and offered push: fill to 5, then OUT_ready=1, IN_valid=1 with 0xAA.
   - Expected: 0xAA is refused that cycle and count becomes 4.
   - Next cycle 0xAA is accepted and count returns to 5.
4. Flush: with count=3, assert IN_flush together with IN_valid (0x55) and OUT_ready.
   - Expected: the next cycle shows count=0, OUT_valid=0, IN_ready=1, and 0x55 is never output.
5. Reset mid-operation: with count=4, drive rst=0 for 1 cycle while IN_flush=1.
   - Expected: all outputs at reset values; a subsequent push of 0x33 appears alone at OUT one cycle later.
6. Bypass (FLOW_FIFO_BYPASS_EN): empty FIFO, IN_valid=1, IN_data=0x77, OUT_ready=1.
   - Expected: OUT_valid=1 and OUT_data=0x77 in the same cycle; count stays 0.
   - With OUT_ready=0 instead: 0x77 is stored and count=1 next cycle.
